// File: rtl/rns_crt_997_decoder_pkg.sv
// Shared constants, FSM encoding and a reference function for the mod-997/1024 CRT decoder.
package rns997_pkg;

  localparam int unsigned M1      = 997;
  localparam int unsigned M2_LOG2 = 10;
  localparam int unsigned INV_M1  = 493;
  localparam int unsigned X_W     = 20;
  localparam int unsigned R1_W    = 10;
  localparam int unsigned X_MAX   = 1020927;

  typedef enum logic [1:0] {
    IDLE,
    MUL_INV,
    MUL_M,
    DONE
  } state_t;

  // Closed-form mixed-radix reconstruction; an out-of-range r1 yields 0.
  function automatic logic [X_W-1:0] crt_ref(input logic [R1_W-1:0] r1,
                                             input logic [M2_LOG2-1:0] r2);
    logic [M2_LOG2-1:0] d;
    logic [M2_LOG2-1:0] t;
    d = r2 - r1;
    t = M2_LOG2'(32'(d) * INV_M1);
    if (32'(r1) >= M1)
      crt_ref = '0;
    else
      crt_ref = X_W'(r1) + X_W'(32'(t) * M1);
  endfunction

endpackage

// File: rtl/rns_crt_997_decoder_if.sv
// Residue-pair in / reconstructed-integer out handshake bundle.
interface rns_crt_997_decoder_if;
  import rns997_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [R1_W-1:0]      in_r1;
  logic [M2_LOG2-1:0]   in_r2;
  logic                 out_valid;
  logic                 out_ready;
  logic [X_W-1:0]       out_x;
  logic                 out_err;

  modport master (
    output in_valid, in_r1, in_r2, out_ready,
    input  in_ready, out_valid, out_x, out_err
  );

  modport slave (
    input  in_valid, in_r1, in_r2, out_ready,
    output in_ready, out_valid, out_x, out_err
  );

endinterface

// File: rtl/rns_crt_997_decoder_serial_const_mac.sv
// Bit-serial shift-add multiply of an operand by CONST, one operand bit per enabled cycle.
// sum is the accumulator including the current cycle's contribution; results wrap at RES_W bits.
module serial_const_mac #(
  parameter int unsigned CONST = 1,
  parameter int unsigned RES_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  input  logic [3:0]       idx,
  output logic [RES_W-1:0] sum
);

  logic [RES_W-1:0] acc;
  logic [RES_W-1:0] addend;

  assign addend = RES_W'(CONST) << idx;
  assign sum    = acc + ((en && bit_in) ? addend : '0);

  always_ff @(posedge clk) begin
    if (rst || clr)
      acc <= '0;
    else if (en)
      acc <= sum;
  end

endmodule

// File: rtl/rns_crt_997_decoder.sv
// Residue pair (mod 997, mod 1024) to binary: t = (r2 - r1) * 493 mod 1024, X = r1 + 997 * t.
// Accept-to-out_valid latency is 21 cycles; one pair in flight, in_ready only while idle.
module rns_crt_997_decoder
  import rns997_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  rns_crt_997_decoder_if.slave bus
);

  localparam logic [3:0] CNT_LAST = 4'(M2_LOG2 - 1);

  state_t              state;
  logic [R1_W-1:0]     r1_q;
  logic [M2_LOG2-1:0]  d_q;
  logic                err_q;
  logic [3:0]          cnt;
  logic                in_rdy;
  logic                out_vld;
  logic [X_W-1:0]      out_x_q;
  logic                out_err_q;

  logic                accept;
  logic [M2_LOG2-1:0]  t;
  logic [X_W-1:0]      x_sum;

  assign accept        = (state == IDLE) && bus.in_valid && in_rdy;
  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_x     = out_x_q;
  assign bus.out_err   = out_err_q;

  // t accumulates modulo 1024 simply by truncation to M2_LOG2 bits.
  serial_const_mac #(.CONST(INV_M1), .RES_W(M2_LOG2)) u_mac_t (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (state == MUL_INV),
    .bit_in (d_q[cnt]),
    .idx    (cnt),
    .sum    (t)
  );

  serial_const_mac #(.CONST(M1), .RES_W(X_W)) u_mac_x (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (state == MUL_M),
    .bit_in (t[cnt]),
    .idx    (cnt),
    .sum    (x_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      r1_q      <= '0;
      d_q       <= '0;
      err_q     <= 1'b0;
      cnt       <= '0;
      in_rdy    <= 1'b1;
      out_vld   <= 1'b0;
      out_x_q   <= '0;
      out_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            r1_q   <= bus.in_r1;
            d_q    <= bus.in_r2 - bus.in_r1;
            err_q  <= (bus.in_r1 >= R1_W'(M1));
            cnt    <= '0;
            in_rdy <= 1'b0;
            state  <= MUL_INV;
          end
        end
        MUL_INV: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= MUL_M;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        MUL_M: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            out_vld <= 1'b1;
            state   <= DONE;
            // x_sum already includes the final bit's contribution this cycle.
            if (err_q) begin
              out_x_q   <= '0;
              out_err_q <= 1'b1;
            end else begin
              out_x_q   <= x_sum + X_W'(r1_q);
              out_err_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_vld   <= 1'b0;
            out_err_q <= 1'b0;
            in_rdy    <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rns_crt_997_decoder.sv
// Directed and random residue pairs checked against a search-based CRT model.
module tb_rns_crt_997_decoder;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rns_crt_997_decoder_if bus ();

  rns_crt_997_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Find the unique X < 997*1024 with X mod 997 = r1 and X mod 1024 = r2.
  function automatic int unsigned model_x(input int unsigned r1, input int unsigned r2);
    for (int unsigned k = 0; k < 1024; k++) begin
      if (((r1 + 997 * k) % 1024) == r2)
        return r1 + 997 * k;
    end
    return 32'hFFFF_FFFF;
  endfunction

  task automatic run_pair(input logic [9:0] r1, input logic [9:0] r2, input int hold);
    int unsigned ex;
    logic        ee;
    int          n;
    int          lat;
    ee = (r1 >= 10'd997);
    ex = ee ? 0 : model_x(32'(r1), 32'(r2));
    @(negedge clk);
    bus.out_ready = (hold == 0);
    bus.in_valid  = 1'b1;
    bus.in_r1     = r1;
    bus.in_r2     = r2;
    n = 0;
    while (!bus.in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 64);
    chk("latency", lat, 21);
    chk("out_x", 32'(bus.out_x), ex);
    chk("out_err", 32'(bus.out_err), 32'(ee));
    if (hold > 0) begin
      // Offer a new pair while the result is stalled; it must not be taken.
      bus.in_valid = 1'b1;
      bus.in_r1    = r2;
      bus.in_r2    = r1;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_x", 32'(bus.out_x), ex);
        chk("hold_err", 32'(bus.out_err), 32'(ee));
        chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("post_valid", 32'(bus.out_valid), 32'd0);
    chk("post_err", 32'(bus.out_err), 32'd0);
    chk("post_x", 32'(bus.out_x), ex);
    chk("post_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_r1     = '0;
    bus.in_r2     = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_x", 32'(bus.out_x), 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    rst = 1'b0;

    run_pair(10'd825, 10'd576, 0);
    run_pair(10'd0, 10'd0, 0);
    run_pair(10'd996, 10'd1023, 0);
    run_pair(10'd5, 10'd5, 0);
    run_pair(10'd1, 10'd0, 0);
    run_pair(10'd1000, 10'd7, 0);
    run_pair(10'd825, 10'd576, 0);
    run_pair(10'd300, 10'd900, 5);

    // Abort inside MUL_M (cycle A+12); no result may appear afterwards.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_r1     = 10'd100;
    bus.in_r2     = 10'd200;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_out_x", 32'(bus.out_x), 32'd0);
    chk("abort_out_err", 32'(bus.out_err), 32'd0);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);

    for (int i = 0; i < 1500; i++) begin
      logic [9:0] a;
      logic [9:0] b;
      a = 10'($urandom_range(0, 1023));
      b = 10'($urandom_range(0, 1023));
      run_pair(a, b, ($urandom_range(0, 15) == 0) ? 2 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
